// File: rtl/j6502_bus_sequencer.sv
// J6502 bus sequencer: derives the phi1/phi2 CPU phase strobes from fst_clk_i and
// time-multiplexes the single-port system RAM between the CPU (slot in phi2) and
// a DMA/loader requester (slot in phi1, req/ack handshake).
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | RAM port free, waiting for the CPU or DMA slot
// CPU_ISSUE | CPU access on the RAM port this cycle
// CPU_DATA  | ram_q_i holds CPU read data, captured into cpu_rdata_o
// DMA_ISSUE | DMA access on the RAM port this cycle
// DMA_DATA  | ram_q_i holds DMA read data, captured into dma_rdata_o with ack
//
// With small DIV the CPU slot can land on DMA_ISSUE or DMA_DATA. The CPU access
// is pipelined behind the DMA one: the port is free in those cycles, and a
// pending DMA read capture (dma_cap_q) completes during CPU_ISSUE.
module j6502_bus_sequencer #(
  parameter int DIV    = 8,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic              fst_clk_i,
  input  logic              res_i,
  output logic              phi1_o,
  output logic              phi2_o,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic              cpu_rd_en_i,
  input  logic              cpu_wr_en_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic              dma_ack_o,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_rden_o,
  output logic              ram_wren_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_q_i
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PH_HALF = PW'(DIV / 2);
  localparam logic [PW-1:0] PH_DMA  = PW'(1);

  typedef enum logic [2:0] {IDLE, CPU_ISSUE, CPU_DATA, DMA_ISSUE, DMA_DATA} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ph_cnt_q, ph_cnt_d;
  logic              phi1_q, phi2_q;
  logic              cpu_rd_q, cpu_rd_d;
  logic              dma_rd_q, dma_rd_d;
  logic              dma_cap_q, dma_cap_d;
  logic              dma_ack_q, dma_ack_d;
  logic              ram_rden_q, ram_rden_d;
  logic              ram_wren_q, ram_wren_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              cpu_go, dma_go, take_cpu, take_dma;

  // State, phase counter and all registered outputs.
  always_ff @(posedge fst_clk_i or posedge res_i) begin
    if (res_i) begin
      state_q     <= IDLE;
      ph_cnt_q    <= '0;
      phi1_q      <= 1'b1;
      phi2_q      <= 1'b0;
      cpu_rd_q    <= 1'b0;
      dma_rd_q    <= 1'b0;
      dma_cap_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      ram_rden_q  <= 1'b0;
      ram_wren_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ph_cnt_q    <= ph_cnt_d;
      phi1_q      <= (ph_cnt_d < PH_HALF);
      phi2_q      <= (ph_cnt_d >= PH_HALF);
      cpu_rd_q    <= cpu_rd_d;
      dma_rd_q    <= dma_rd_d;
      dma_cap_q   <= dma_cap_d;
      dma_ack_q   <= dma_ack_d;
      ram_rden_q  <= ram_rden_d;
      ram_wren_q  <= ram_wren_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Phase advance, slot arbitration and next-state / output decode.
  always_comb begin
    ph_cnt_d    = (ph_cnt_q == PH_LAST) ? '0 : ph_cnt_q + 1'b1;
    cpu_go      = (ph_cnt_q == PH_HALF) && (cpu_rd_en_i || cpu_wr_en_i);
    dma_go      = (ph_cnt_q == PH_DMA) && dma_req_i;
    state_d     = state_q;
    cpu_rd_d    = cpu_rd_q;
    dma_rd_d    = dma_rd_q;
    dma_cap_d   = 1'b0;
    dma_ack_d   = 1'b0;
    ram_rden_d  = 1'b0;
    ram_wren_d  = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    take_cpu    = 1'b0;
    take_dma    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_go)      take_cpu = 1'b1;
        else if (dma_go) take_dma = 1'b1;
      end
      CPU_ISSUE: begin
        if (dma_cap_q) begin
          dma_rdata_d = ram_q_i;
          dma_ack_d   = 1'b1;
        end
        state_d = cpu_rd_q ? CPU_DATA : IDLE;
      end
      CPU_DATA: begin
        cpu_rdata_d = ram_q_i;
        state_d     = IDLE;
      end
      DMA_ISSUE: begin
        if (cpu_go) begin
          take_cpu  = 1'b1;
          dma_cap_d = dma_rd_q;
        end else begin
          state_d = dma_rd_q ? DMA_DATA : IDLE;
        end
      end
      DMA_DATA: begin
        dma_rdata_d = ram_q_i;
        dma_ack_d   = 1'b1;
        if (cpu_go) take_cpu = 1'b1;
        else        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A simultaneous rd+wr from the CPU is treated as a write.
    if (take_cpu) begin
      state_d    = CPU_ISSUE;
      cpu_rd_d   = cpu_rd_en_i && !cpu_wr_en_i;
      ram_addr_d = cpu_addr_i;
      ram_rden_d = cpu_rd_en_i && !cpu_wr_en_i;
      ram_wren_d = cpu_wr_en_i;
      if (cpu_wr_en_i) ram_wdata_d = cpu_wdata_i;
    end else if (take_dma) begin
      state_d    = DMA_ISSUE;
      dma_rd_d   = !dma_we_i;
      ram_addr_d = dma_addr_i;
      ram_rden_d = !dma_we_i;
      ram_wren_d = dma_we_i;
      dma_ack_d  = dma_we_i;
      if (dma_we_i) ram_wdata_d = dma_wdata_i;
    end
  end

  assign phi1_o      = phi1_q;
  assign phi2_o      = phi2_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign dma_ack_o   = dma_ack_q;
  assign dma_rdata_o = dma_rdata_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_rden_o  = ram_rden_q;
  assign ram_wren_o  = ram_wren_q;
  assign ram_wdata_o = ram_wdata_q;

endmodule

// File: tb/tb_j6502_bus_sequencer.sv
// Directed bench for j6502_bus_sequencer: a DIV=8 instance and a DIV=4 instance,
// each in front of its own behavioural single-port RAM.
module tb_j6502_bus_sequencer;

  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // DIV=8 instance signals
  logic [14:0] c_addr = '0, d_addr = '0, ram_addr;
  logic        c_rd = 0, c_wr = 0, d_req = 0, d_we = 0;
  logic [7:0]  c_wdata = '0, d_wdata = '0;
  logic        phi1, phi2, dma_ack, ram_rden, ram_wren;
  logic [7:0]  cpu_rdata, dma_rdata, ram_wdata, ram_q;

  // DIV=4 instance signals
  logic [14:0] c4_addr = '0, d4_addr = '0, ram4_addr;
  logic        c4_rd = 0, c4_wr = 0, d4_req = 0, d4_we = 0;
  logic [7:0]  c4_wdata = '0, d4_wdata = '0;
  logic        phi1_4, phi2_4, dma_ack4, ram4_rden, ram4_wren;
  logic [7:0]  cpu_rdata4, dma_rdata4, ram4_wdata, ram4_q;

  j6502_bus_sequencer #(.DIV(8), .ADDR_W(15), .DATA_W(8)) u8 (
    .fst_clk_i(clk), .res_i(res), .phi1_o(phi1), .phi2_o(phi2),
    .cpu_addr_i(c_addr), .cpu_rd_en_i(c_rd), .cpu_wr_en_i(c_wr), .cpu_wdata_i(c_wdata),
    .cpu_rdata_o(cpu_rdata), .dma_req_i(d_req), .dma_we_i(d_we), .dma_addr_i(d_addr),
    .dma_wdata_i(d_wdata), .dma_ack_o(dma_ack), .dma_rdata_o(dma_rdata),
    .ram_addr_o(ram_addr), .ram_rden_o(ram_rden), .ram_wren_o(ram_wren),
    .ram_wdata_o(ram_wdata), .ram_q_i(ram_q));

  j6502_bus_sequencer #(.DIV(4), .ADDR_W(15), .DATA_W(8)) u4 (
    .fst_clk_i(clk), .res_i(res), .phi1_o(phi1_4), .phi2_o(phi2_4),
    .cpu_addr_i(c4_addr), .cpu_rd_en_i(c4_rd), .cpu_wr_en_i(c4_wr), .cpu_wdata_i(c4_wdata),
    .cpu_rdata_o(cpu_rdata4), .dma_req_i(d4_req), .dma_we_i(d4_we), .dma_addr_i(d4_addr),
    .dma_wdata_i(d4_wdata), .dma_ack_o(dma_ack4), .dma_rdata_o(dma_rdata4),
    .ram_addr_o(ram4_addr), .ram_rden_o(ram4_rden), .ram_wren_o(ram4_wren),
    .ram_wdata_o(ram4_wdata), .ram_q_i(ram4_q));

  // Behavioural RAMs with a preload port (read data valid the cycle after rden).
  logic [7:0]  mem  [0:32767];
  logic [7:0]  mem4 [0:32767];
  logic        pl_en = 0, pl4_en = 0;
  logic [14:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  always @(posedge clk) begin
    if (pl_en)    mem[pl_addr] <= pl_data;
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    if (ram_rden) ram_q <= mem[ram_addr];
  end

  always @(posedge clk) begin
    if (pl4_en)    mem4[pl_addr] <= pl_data;
    if (ram4_wren) mem4[ram4_addr] <= ram4_wdata;
    if (ram4_rden) ram4_q <= mem4[ram4_addr];
  end

  task tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task wait_ph8(input int p);
    do tick(); while (cyc % 8 != p);
  endtask

  task preload(input logic four, input logic [14:0] a, input logic [7:0] d);
    pl_addr = a; pl_data = d;
    if (four) pl4_en = 1; else pl_en = 1;
    @(posedge clk); #1;
    pl_en = 0; pl4_en = 0;
  endtask

  task test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (phi1 !== 1'b1) begin failures++; $display("FAIL reset_phi1 got=%0b exp=1", phi1); end
    checks++; if (phi2 !== 1'b0) begin failures++; $display("FAIL reset_phi2 got=%0b exp=0", phi2); end
    checks++; if ({ram_rden, ram_wren, dma_ack} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {ram_rden, ram_wren, dma_ack}); end
    checks++; if (ram_addr !== 15'h0) begin failures++; $display("FAIL reset_ram_addr got=%0h exp=0", ram_addr); end
    checks++; if ({cpu_rdata, dma_rdata, ram_wdata} !== 24'h0) begin failures++; $display("FAIL reset_data got=%0h exp=0", {cpu_rdata, dma_rdata, ram_wdata}); end
    checks++; if ({phi1_4, phi2_4} !== 2'b10) begin failures++; $display("FAIL reset_phi_div4 got=%b exp=10", {phi1_4, phi2_4}); end
  endtask

  task release_reset();
    res = 0;
    cyc = 0;
  endtask

  task test_phase();
    for (int k = 0; k < 24; k++) begin
      tick();
      checks++;
      if ({phi1, phi2} !== (((cyc % 8) < 4) ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL phase_div8 cyc=%0d got=%b", cyc, {phi1, phi2});
      end
      checks++;
      if ({phi1_4, phi2_4} !== (((cyc % 4) < 2) ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL phase_div4 cyc=%0d got=%b", cyc, {phi1_4, phi2_4});
      end
    end
  endtask

  task test_cpu_read();
    wait_ph8(4);
    c_addr = 15'h0123; c_rd = 1;
    tick();
    checks++; if ({ram_rden, ram_wren} !== 2'b10) begin failures++; $display("FAIL cpu_rd_issue got=%b exp=10", {ram_rden, ram_wren}); end
    checks++; if (ram_addr !== 15'h0123) begin failures++; $display("FAIL cpu_rd_addr got=%0h exp=123", ram_addr); end
    c_rd = 0;
    tick();
    checks++; if (ram_rden !== 1'b0) begin failures++; $display("FAIL cpu_rd_pulse got=%0b exp=0", ram_rden); end
    tick();
    checks++; if (cpu_rdata !== 8'hA5) begin failures++; $display("FAIL cpu_rdata got=%0h exp=a5", cpu_rdata); end
    repeat (4) tick();
    checks++; if (cpu_rdata !== 8'hA5 || phi1 !== 1'b1) begin failures++; $display("FAIL cpu_rdata_hold got=%0h phi1=%0b exp=a5 1", cpu_rdata, phi1); end
  endtask

  task test_dma_write_read();
    wait_ph8(1);
    d_req = 1; d_we = 1; d_addr = 15'h7FFF; d_wdata = 8'h3C;
    tick();
    checks++; if ({ram_wren, ram_rden, dma_ack} !== 3'b101) begin failures++; $display("FAIL dma_wr_issue got=%b exp=101", {ram_wren, ram_rden, dma_ack}); end
    checks++; if (ram_addr !== 15'h7FFF || ram_wdata !== 8'h3C) begin failures++; $display("FAIL dma_wr_operands got=%0h/%0h exp=7fff/3c", ram_addr, ram_wdata); end
    d_we = 0;
    tick();
    checks++; if (dma_ack !== 1'b0) begin failures++; $display("FAIL dma_wr_ack_pulse got=%0b exp=0", dma_ack); end
    wait_ph8(1);
    tick();
    checks++; if ({ram_rden, dma_ack} !== 2'b10 || ram_addr !== 15'h7FFF) begin failures++; $display("FAIL dma_rd_issue got=%b addr=%0h exp=10 7fff", {ram_rden, dma_ack}, ram_addr); end
    tick();
    checks++; if (dma_ack !== 1'b0) begin failures++; $display("FAIL dma_rd_early_ack got=%0b exp=0", dma_ack); end
    tick();
    checks++; if (dma_ack !== 1'b1 || dma_rdata !== 8'h3C) begin failures++; $display("FAIL dma_rd_data ack=%0b got=%0h exp=1 3c", dma_ack, dma_rdata); end
    d_req = 0;
  endtask

  task test_cpu_dma_concurrent();
    int acks;
    wait_ph8(0);
    d_req = 1; d_we = 0; d_addr = 15'h0010;
    for (int g = 0; g < 3; g++) begin
      acks = 0;
      for (int s = 0; s < 8; s++) begin
        tick();
        checks++;
        if ((ram_rden & ram_wren) !== 1'b0) begin failures++; $display("FAIL conc_overlap cyc=%0d got=1 exp=0", cyc); end
        if (dma_ack) begin
          acks++;
          checks++;
          if (dma_rdata !== ((g == 2) ? 8'h55 : 8'h11)) begin failures++; $display("FAIL conc_dma_rdata group=%0d got=%0h", g, dma_rdata); end
        end
        if (g == 1 && cyc % 8 == 5) begin
          checks++;
          if (ram_wren !== 1'b1 || ram_addr !== 15'h0010 || ram_wdata !== 8'h55) begin
            failures++; $display("FAIL conc_cpu_write wren=%0b addr=%0h data=%0h exp=1 10 55", ram_wren, ram_addr, ram_wdata);
          end
          c_wr = 0;
        end
        if (g == 1 && cyc % 8 == 4) begin
          c_addr = 15'h0010; c_wdata = 8'h55; c_wr = 1;
        end
      end
      checks++; if (acks != 1) begin failures++; $display("FAIL conc_acks_per_cycle group=%0d got=%0d exp=1", g, acks); end
    end
    d_req = 0;
    tick(); tick();
    checks++; if (ram_rden !== 1'b0) begin failures++; $display("FAIL dropped_req_issued got=%0b exp=0", ram_rden); end
    tick(); tick();
    checks++; if (dma_ack !== 1'b0) begin failures++; $display("FAIL dropped_req_ack got=%0b exp=0", dma_ack); end
  endtask

  task test_drop_after_sample();
    wait_ph8(1);
    d_req = 1; d_we = 0; d_addr = 15'h0123;
    tick();
    d_req = 0;
    tick(); tick();
    checks++; if (dma_ack !== 1'b1 || dma_rdata !== 8'hA5) begin failures++; $display("FAIL drop_after_sample ack=%0b got=%0h exp=1 a5", dma_ack, dma_rdata); end
  endtask

  task test_reset_mid_access();
    int acks;
    wait_ph8(1);
    d_req = 1; d_we = 0; d_addr = 15'h7FFF;
    tick(); tick();
    res = 1;
    #1;
    checks++; if ({dma_ack, ram_rden, ram_wren} !== 3'b000) begin failures++; $display("FAIL midrst_strobes got=%b exp=000", {dma_ack, ram_rden, ram_wren}); end
    checks++; if ({phi1, phi2} !== 2'b10) begin failures++; $display("FAIL midrst_phi got=%b exp=10", {phi1, phi2}); end
    checks++; if (ram_addr !== 15'h0 || dma_rdata !== 8'h0 || cpu_rdata !== 8'h0) begin failures++; $display("FAIL midrst_outs got=%0h/%0h/%0h exp=0", ram_addr, dma_rdata, cpu_rdata); end
    d_req = 0;
    @(posedge clk); #1;
    release_reset();
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (dma_ack) acks++;
      checks++;
      if ({phi1, phi2} !== (((cyc % 8) < 4) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL midrst_restart_phase cyc=%0d got=%b", cyc, {phi1, phi2}); end
    end
    checks++; if (acks != 0) begin failures++; $display("FAIL midrst_spurious_ack got=%0d exp=0", acks); end
  endtask

  task test_div4_back_to_back();
    do tick(); while (cyc % 4 != 1);
    d4_req = 1; d4_we = 0; d4_addr = 15'h0200;
    c4_rd = 1; c4_addr = 15'h0300;
    tick();
    checks++; if ({ram4_rden, ram4_wren} !== 2'b10 || ram4_addr !== 15'h0200) begin failures++; $display("FAIL div4_dma_issue got=%b addr=%0h exp=10 200", {ram4_rden, ram4_wren}, ram4_addr); end
    tick();
    checks++; if ({ram4_rden, ram4_wren} !== 2'b10 || ram4_addr !== 15'h0300 || dma_ack4 !== 1'b0) begin failures++; $display("FAIL div4_cpu_issue got=%b addr=%0h ack=%0b exp=10 300 0", {ram4_rden, ram4_wren}, ram4_addr, dma_ack4); end
    tick();
    checks++; if (dma_ack4 !== 1'b1 || dma_rdata4 !== 8'h5A || ram4_rden !== 1'b0) begin failures++; $display("FAIL div4_dma_data ack=%0b got=%0h rden=%0b exp=1 5a 0", dma_ack4, dma_rdata4, ram4_rden); end
    d4_req = 0; c4_rd = 0;
    tick();
    checks++; if (cpu_rdata4 !== 8'hC3 || dma_ack4 !== 1'b0) begin failures++; $display("FAIL div4_cpu_data got=%0h ack=%0b exp=c3 0", cpu_rdata4, dma_ack4); end
    tick();
    checks++; if (ram4_rden !== 1'b0) begin failures++; $display("FAIL div4_no_reissue got=%0b exp=0", ram4_rden); end
  endtask

  initial begin
    test_reset();
    preload(1'b0, 15'h0123, 8'hA5);
    preload(1'b0, 15'h0010, 8'h11);
    preload(1'b1, 15'h0200, 8'h5A);
    preload(1'b1, 15'h0300, 8'hC3);
    release_reset();
    test_phase();
    test_cpu_read();
    test_dma_write_read();
    test_cpu_dma_concurrent();
    test_drop_after_sample();
    test_reset_mid_access();
    test_cpu_read();
    test_div4_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
